// File: rtl/snes_pkg.sv
// ============================================================================
// Module : snes_pkg
// Brief  : Shared SNES pad constants, button indices and responder states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package snes_pkg;

    localparam int SNES_NUM_BITS = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } snes_state_e;

endpackage

`default_nettype wire

// File: rtl/snes_pad_responder_if.sv
// ============================================================================
// Module : snes_pad_responder_if
// Brief  : Button word and host-side serial pins of the pad responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface snes_pad_responder_if;
    import snes_pkg::*;

    logic [SNES_NUM_BITS-1:0] buttons;
    logic                     snes_latch;
    logic                     snes_clock;
    logic                     snes_data;
    logic [4:0]               bit_count;
    logic                     frame_done;

    modport master (
        output buttons, snes_latch, snes_clock,
        input  snes_data, bit_count, frame_done
    );

    modport slave (
        input  buttons, snes_latch, snes_clock,
        output snes_data, bit_count, frame_done
    );

endinterface

`default_nettype wire

// File: rtl/snes_sync_edge.sv
// ============================================================================
// Module : snes_sync_edge
// Brief  : N-stage synchronizer with reset value, plus registered level/edges.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module snes_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    // r_prev doubles as the synced level, aligned with the edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/snes_pad_responder.sv
// ============================================================================
// Module : snes_pad_responder
// Brief  : Emulates an SNES pad: snapshots buttons on latch, shifts on clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 rst,
    snes_pad_responder_if.slave  pad
);

    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]        c_BC_LAST = 5'(SNES_NUM_BITS - 1);
    localparam logic [4:0]        c_BC_DONE = 5'(SNES_NUM_BITS);

    logic w_latch_level, w_latch_rise, w_latch_fall;
    logic w_clk_level, w_clk_rise, w_clk_fall;

    snes_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_latch (
        .clk     (clock),
        .rst     (rst),
        .i_async (pad.snes_latch),
        .o_level (w_latch_level),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    snes_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clock (
        .clk     (clock),
        .rst     (rst),
        .i_async (pad.snes_clock),
        .o_level (w_clk_level),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    snes_state_e                r_state, w_state_nxt;
    logic [SNES_NUM_BITS-1:0]   r_sr, w_sr_nxt;
    logic [c_TO_W-1:0]          r_timeout, w_to_nxt;
    logic                       r_data, w_data_nxt;
    logic [4:0]                 r_bit_count, w_bc_nxt;
    logic                       r_frame_done, w_fd_nxt;

    // Latch level already covers the rising edge; sr[0] is consumed before the shift
    logic w_unused_sync;
    assign w_unused_sync = w_latch_rise ^ w_clk_level ^ w_clk_fall ^ r_sr[0];

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sr         <= '0;
            r_timeout    <= '0;
            r_data       <= 1'b1;
            r_bit_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sr         <= w_sr_nxt;
            r_timeout    <= w_to_nxt;
            r_data       <= w_data_nxt;
            r_bit_count  <= w_bc_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    // A high latch overrides everything, including a coincident clock edge
    always_comb begin
        w_state_nxt = r_state;
        if (w_latch_level) begin
            w_state_nxt = ST_LATCH;
        end else begin
            case (r_state)
                ST_LATCH: if (w_latch_fall) w_state_nxt = ST_SHIFT;
                ST_SHIFT: begin
                    if (w_clk_rise) begin
                        if (r_bit_count == c_BC_LAST) w_state_nxt = ST_DONE;
                    end else if (r_timeout == c_TO_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_sr_nxt   = r_sr;
        w_to_nxt   = '0;
        w_data_nxt = r_data;
        w_bc_nxt   = r_bit_count;
        w_fd_nxt   = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_data_nxt = 1'b1;
                w_bc_nxt   = '0;
            end
            ST_LATCH: begin
                w_sr_nxt   = pad.buttons;
                w_data_nxt = ~pad.buttons[BTN_B];
                w_bc_nxt   = '0;
            end
            ST_SHIFT: begin
                if (r_state == ST_SHIFT) begin
                    if (w_clk_rise) begin
                        w_sr_nxt   = r_sr >> 1;
                        w_data_nxt = ~r_sr[1];
                        w_bc_nxt   = r_bit_count + 5'd1;
                    end else begin
                        w_to_nxt = r_timeout + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_data_nxt = 1'b0;
                if (r_state == ST_SHIFT) begin
                    w_sr_nxt = r_sr >> 1;
                    w_bc_nxt = c_BC_DONE;
                    w_fd_nxt = 1'b1;
                end
            end
            default: w_data_nxt = 1'b1;
        endcase
    end

    assign pad.snes_data  = r_data;
    assign pad.bit_count  = r_bit_count;
    assign pad.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_snes_pad_responder.sv
// Bench for snes_pad_responder: behaves as an SNES host at 4 MHz system clock,
// compares each sampled wire bit to the pad rules (wire = ~button, trailer 0).
`timescale 1ns/1ps
`default_nettype none

module tb_snes_pad_responder;
    import snes_pkg::*;

    localparam int c_HALF_NS     = 125;
    localparam int c_LATCH_CYC   = 48;
    localparam int c_CLKHALF_CYC = 12;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    snes_pad_responder_if pad();

    snes_pad_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1024)) dut (
        .clock (clock),
        .rst   (rst),
        .pad   (pad.slave)
    );

    always #c_HALF_NS clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int fd_count    = 0;

    always @(posedge clock) if (pad.frame_done === 1'b1) fd_count++;

    // Reference: what a real pad puts on the wire for host sample idx
    function automatic logic ref_wire(input logic [15:0] snap, input int idx);
        return (idx < SNES_NUM_BITS) ? ~snap[idx] : 1'b0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic latch_pulse();
        @(negedge clock);
        pad.snes_latch = 1'b1;
        wait_cycles(c_LATCH_CYC);
        pad.snes_latch = 1'b0;
        wait_cycles(c_CLKHALF_CYC);
    endtask

    task automatic clock_pulse();
        pad.snes_clock = 1'b0;
        wait_cycles(c_CLKHALF_CYC);
        pad.snes_clock = 1'b1;
        wait_cycles(c_CLKHALF_CYC);
    endtask

    task automatic read_frame(input int n, output logic [15:0] bits, output logic [79:0] cnts);
        bits = '0;
        cnts = '0;
        for (int i = 0; i < n; i++) begin
            bits[i]        = pad.snes_data;
            cnts[i*5 +: 5] = pad.bit_count;
            clock_pulse();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(20);
        vectors++;
        if (pad.snes_data !== 1'b1 || pad.bit_count !== 5'd0 || pad.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in: data=%b cnt=%0d fd=%b, expected 1/0/0", pad.snes_data, pad.bit_count, pad.frame_done);
        end
        rst = 1'b0;
        wait_cycles(20);
        vectors++;
        if (pad.snes_data !== 1'b1 || pad.bit_count !== 5'd0 || pad.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: data=%b cnt=%0d fd=%b, expected 1/0/0", pad.snes_data, pad.bit_count, pad.frame_done);
        end
    endtask

    task automatic test_single_b();
        logic [15:0] snap, bits;
        logic [79:0] cnts;
        int fd0;
        snap = 16'h0001;
        pad.buttons = snap;
        fd0 = fd_count;
        @(negedge clock);
        pad.snes_latch = 1'b1;
        wait_cycles(3);
        vectors++;
        if (pad.snes_data !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_early: data=%b expected 1", pad.snes_data);
        end
        wait_cycles(1);
        vectors++;
        if (pad.snes_data !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_4: data=%b expected 0", pad.snes_data);
        end
        wait_cycles(c_LATCH_CYC - 4);
        pad.snes_latch = 1'b0;
        wait_cycles(c_CLKHALF_CYC);
        read_frame(16, bits, cnts);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (bits[i] !== ref_wire(snap, i) || cnts[i*5 +: 5] !== 5'(i)) begin
                miscompares++;
                $display("FAIL b_bit%0d: wire=%b cnt=%0d, expected wire=%b cnt=%0d",
                         i, bits[i], cnts[i*5 +: 5], ref_wire(snap, i), i);
            end
        end
        vectors++;
        if (pad.snes_data !== ref_wire(snap, 16) || pad.bit_count !== 5'd16 || fd_count - fd0 !== 1) begin
            miscompares++;
            $display("FAIL b_trailer: data=%b cnt=%0d pulses=%0d, expected 0/16/1", pad.snes_data, pad.bit_count, fd_count - fd0);
        end
        clock_pulse();
        clock_pulse();
        vectors++;
        if (pad.snes_data !== 1'b0 || pad.bit_count !== 5'd16 || fd_count - fd0 !== 1) begin
            miscompares++;
            $display("FAIL done_ignore: data=%b cnt=%0d pulses=%0d, expected 0/16/1", pad.snes_data, pad.bit_count, fd_count - fd0);
        end
    endtask

    task automatic test_pattern(input logic [15:0] snap, input logic [15:0] after);
        logic [15:0] bits;
        logic [79:0] cnts;
        int fd0;
        fd0 = fd_count;
        pad.buttons = snap;
        latch_pulse();
        pad.buttons = after;
        read_frame(16, bits, cnts);
        vectors++;
        if (~bits !== snap) begin
            miscompares++;
            $display("FAIL pattern_word: host read %h, expected %h", ~bits, snap);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (cnts[i*5 +: 5] !== 5'(i)) begin
                miscompares++;
                $display("FAIL pattern_cnt%0d: cnt=%0d expected %0d", i, cnts[i*5 +: 5], i);
            end
        end
        vectors++;
        if (fd_count - fd0 !== 1 || pad.snes_data !== 1'b0) begin
            miscompares++;
            $display("FAIL pattern_done: pulses=%0d data=%b, expected 1/0", fd_count - fd0, pad.snes_data);
        end
    endtask

    task automatic test_abort();
        logic [15:0] snap, bits;
        logic [79:0] cnts;
        int fd0;
        fd0 = fd_count;
        pad.buttons = 16'($urandom) | 16'h0001;
        latch_pulse();
        read_frame(7, bits, cnts);
        vectors++;
        if (pad.bit_count !== 5'd7) begin
            miscompares++;
            $display("FAIL abort_mid: cnt=%0d expected 7", pad.bit_count);
        end
        snap = 16'h0800;
        pad.buttons = snap;
        pad.snes_latch = 1'b1;
        wait_cycles(6);
        vectors++;
        if (pad.bit_count !== 5'd0 || pad.snes_data !== ref_wire(snap, 0) || fd_count !== fd0) begin
            miscompares++;
            $display("FAIL abort_reload: cnt=%0d data=%b pulses=%0d, expected 0/1/0", pad.bit_count, pad.snes_data, fd_count - fd0);
        end
        wait_cycles(c_LATCH_CYC);
        pad.snes_latch = 1'b0;
        wait_cycles(c_CLKHALF_CYC);
        read_frame(16, bits, cnts);
        vectors++;
        if (~bits !== snap || fd_count - fd0 !== 1) begin
            miscompares++;
            $display("FAIL abort_frame: host read %h pulses=%0d, expected %h/1", ~bits, fd_count - fd0, snap);
        end
    endtask

    task automatic test_coincident();
        logic [15:0] snap, bits;
        logic [79:0] cnts;
        int fd0;
        snap = 16'($urandom) | 16'h0001;
        pad.buttons = snap;
        latch_pulse();
        read_frame(3, bits, cnts);
        fd0 = fd_count;
        pad.snes_clock = 1'b0;
        wait_cycles(c_CLKHALF_CYC);
        pad.snes_latch = 1'b1;
        pad.snes_clock = 1'b1;
        wait_cycles(8);
        vectors++;
        if (pad.bit_count !== 5'd0 || pad.snes_data !== ref_wire(snap, 0)) begin
            miscompares++;
            $display("FAIL coincident: cnt=%0d data=%b, expected 0/%b", pad.bit_count, pad.snes_data, ref_wire(snap, 0));
        end
        clock_pulse();
        clock_pulse();
        clock_pulse();
        vectors++;
        if (pad.bit_count !== 5'd0 || pad.snes_data !== ref_wire(snap, 0)) begin
            miscompares++;
            $display("FAIL clk_in_latch: cnt=%0d data=%b, expected 0/%b", pad.bit_count, pad.snes_data, ref_wire(snap, 0));
        end
        pad.snes_latch = 1'b0;
        wait_cycles(c_CLKHALF_CYC);
        read_frame(16, bits, cnts);
        vectors++;
        if (~bits !== snap || fd_count - fd0 !== 1) begin
            miscompares++;
            $display("FAIL coincident_frame: host read %h pulses=%0d, expected %h/1", ~bits, fd_count - fd0, snap);
        end
    endtask

    task automatic test_timeout();
        int fd0;
        pad.buttons = 16'($urandom) | 16'h0001;
        fd0 = fd_count;
        latch_pulse();
        wait_cycles(1000 - c_CLKHALF_CYC);
        vectors++;
        if (pad.snes_data !== 1'b0 || pad.bit_count !== 5'd0) begin
            miscompares++;
            $display("FAIL timeout_early: data=%b cnt=%0d, expected 0/0", pad.snes_data, pad.bit_count);
        end
        wait_cycles(60);
        vectors++;
        if (pad.snes_data !== 1'b1 || pad.bit_count !== 5'd0 || fd_count !== fd0) begin
            miscompares++;
            $display("FAIL timeout_idle: data=%b cnt=%0d pulses=%0d, expected 1/0/0", pad.snes_data, pad.bit_count, fd_count - fd0);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] snap, bits;
        logic [79:0] cnts;
        pad.buttons = 16'($urandom) | 16'h0001;
        latch_pulse();
        read_frame(5, bits, cnts);
        rst = 1'b1;
        wait_cycles(1);
        vectors++;
        if (pad.snes_data !== 1'b1 || pad.bit_count !== 5'd0 || pad.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_shift: data=%b cnt=%0d fd=%b, expected 1/0/0", pad.snes_data, pad.bit_count, pad.frame_done);
        end
        rst = 1'b0;
        wait_cycles(4);
        snap = 16'($urandom);
        pad.buttons = snap;
        latch_pulse();
        read_frame(16, bits, cnts);
        vectors++;
        if (~bits !== snap) begin
            miscompares++;
            $display("FAIL reset_recover: host read %h, expected %h", ~bits, snap);
        end
    endtask

    initial begin
        pad.buttons    = '0;
        pad.snes_latch = 1'b0;
        pad.snes_clock = 1'b1;
        test_reset();
        test_single_b();
        test_pattern(16'hA5C3, 16'hFFFF);
        for (int k = 0; k < 4; k++) test_pattern(16'($urandom), 16'($urandom));
        test_abort();
        test_coincident();
        test_timeout();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
